// File: rtl/snake_frame_writer_if.sv
// Board RAM write port: one cell write per wr_en && wr_ready beat.
// The writer drives the master side and the RAM drives the slave side.
interface snake_frame_writer_if #(
    parameter int COORD_W = 4,
    parameter int CELL_W  = 2
);
    logic               wr_en;
    logic               wr_ready;
    logic [COORD_W-1:0] x_loc;
    logic [COORD_W-1:0] y_loc;
    logic [CELL_W-1:0]  data_out;

    modport master (
        output wr_en, x_loc, y_loc, data_out,
        input  wr_ready
    );

    modport slave (
        input  wr_en, x_loc, y_loc, data_out,
        output wr_ready
    );
endinterface

// File: rtl/snake_frame_writer.sv
// Streams a snapshot of the snake segment list into the board RAM,
// one cell per handshake, head first, then pulses done.
module snake_frame_writer #(
    parameter int               COORD_W    = 4,
    parameter int               MAX_SEG    = 225,
    parameter int               CELL_W     = 2,
    parameter logic [CELL_W-1:0] HEAD_CODE  = 2'b11,
    parameter logic [CELL_W-1:0] BODY_CODE  = 2'b10,
    parameter logic [CELL_W-1:0] EMPTY_CODE = 2'b00,
    localparam int              SEG_W      = 2 * COORD_W,
    localparam int              LEN_W      = $clog2(MAX_SEG + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     erase,
    input  logic [LEN_W-1:0]         length,
    input  logic [MAX_SEG*SEG_W-1:0] snake_in,
    snake_frame_writer_if.master     wr,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FINISH
    } state_t;

    state_t                   state;
    logic [MAX_SEG*SEG_W-1:0] snake_q;
    logic                     erase_q;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         idx;
    logic [LEN_W-1:0]         idx_nxt;
    logic [LEN_W-1:0]         len_clamp;
    logic [SEG_W-1:0]         seg0;
    logic [SEG_W-1:0]         seg_nxt;

    assign len_clamp = (length > LEN_W'(MAX_SEG)) ? LEN_W'(MAX_SEG) : length;
    assign idx_nxt   = idx + LEN_W'(1);
    assign seg0      = snake_in[SEG_W-1:0];
    // idx_nxt only runs past the list on the last beat, where it is unused
    assign seg_nxt   = snake_q[int'(idx_nxt)*SEG_W +: SEG_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wr.wr_en    <= 1'b0;
            wr.x_loc    <= '0;
            wr.y_loc    <= '0;
            wr.data_out <= EMPTY_CODE;
            busy        <= 1'b0;
            done        <= 1'b0;
            idx         <= '0;
            len_q       <= '0;
            erase_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        snake_q <= snake_in;
                        erase_q <= erase;
                        len_q   <= len_clamp;
                        idx     <= '0;
                        if (len_clamp == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state       <= WRITE;
                            busy        <= 1'b1;
                            wr.wr_en    <= 1'b1;
                            wr.x_loc    <= seg0[COORD_W-1:0];
                            wr.y_loc    <= seg0[SEG_W-1:COORD_W];
                            wr.data_out <= erase ? EMPTY_CODE : HEAD_CODE;
                        end
                    end
                end
                WRITE: begin
                    if (wr.wr_ready) begin
                        if (idx_nxt == len_q) begin
                            state    <= FINISH;
                            wr.wr_en <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            idx         <= idx_nxt;
                            wr.x_loc    <= seg_nxt[COORD_W-1:0];
                            wr.y_loc    <= seg_nxt[SEG_W-1:COORD_W];
                            wr.data_out <= erase_q ? EMPTY_CODE : BODY_CODE;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_frame_writer.sv
// Scoreboard bench for snake_frame_writer: directed passes push expected
// writes and done cycles, a negedge monitor pops and compares them.
module tb_snake_frame_writer;

    localparam int CW  = 4;
    localparam int MS  = 225;
    localparam int SW  = 2 * CW;
    localparam int LW  = 8;
    localparam int CW2 = 5;
    localparam int MS2 = 4;
    localparam int SW2 = 2 * CW2;
    localparam int LW2 = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             erase;
    logic [LW-1:0]    length;
    logic [MS*SW-1:0] snake_in;
    logic             busy;
    logic             done;

    logic               start2;
    logic               erase2;
    logic [LW2-1:0]     length2;
    logic [MS2*SW2-1:0] snake2;
    logic               busy2;
    logic               done2;

    snake_frame_writer_if #(.COORD_W(CW), .CELL_W(2)) wr ();
    snake_frame_writer_if #(.COORD_W(CW2), .CELL_W(2)) wr2 ();

    snake_frame_writer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .erase    (erase),
        .length   (length),
        .snake_in (snake_in),
        .wr       (wr),
        .busy     (busy),
        .done     (done)
    );

    snake_frame_writer #(.COORD_W(CW2), .MAX_SEG(MS2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .start    (start2),
        .erase    (erase2),
        .length   (length2),
        .snake_in (snake2),
        .wr       (wr2),
        .busy     (busy2),
        .done     (done2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         st;
        int         cyc;
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] d;
    } wexp_t;

    wexp_t      wq[$];
    int         dq[$];
    int         checks = 0;
    int         errors = 0;
    int         hs_cnt = 0;
    bit         mon_en = 1'b0;
    logic [SW-1:0] segs[MS];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", busy, (wq.size() > 0 && cyc > wq[0].st) ? 1 : 0);
            if (wr.wr_en) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: x=%0d y=%0d d=%0d (cycle %0d)",
                             wr.x_loc, wr.y_loc, wr.data_out, cyc);
                end else begin
                    chk("x_loc", wr.x_loc, wq[0].x);
                    chk("y_loc", wr.y_loc, wq[0].y);
                    chk("data_out", wr.data_out, wq[0].d);
                    if (wr.wr_ready) begin
                        chk("write_cycle", cyc, wq[0].cyc);
                        void'(wq.pop_front());
                        hs_cnt++;
                    end
                end
            end
            if (dq.size() > 0 && dq[0] == cyc) begin
                chk("done", done, 1);
                void'(dq.pop_front());
            end else if (done) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got 1 expected 0 (cycle %0d)", cyc);
            end
        end
    end

    task automatic do_pass(input int len, input bit er, input int stall_idx,
                           input int stall_n, input bit perturb);
        int    lc;
        int    t;
        int    dc;
        wexp_t e;
        @(posedge clk);
        #1;
        t  = cyc;
        lc = (len > MS) ? MS : len;
        for (int i = 0; i < MS; i++) snake_in[i*SW +: SW] = segs[i];
        start       = 1'b1;
        erase       = er;
        length      = LW'(len);
        wr.wr_ready = 1'b1;
        for (int i = 0; i < lc; i++) begin
            e.st  = t;
            e.cyc = t + 1 + i + ((stall_n > 0 && i >= stall_idx) ? stall_n : 0);
            e.x   = segs[i][3:0];
            e.y   = segs[i][7:4];
            e.d   = er ? 2'b00 : ((i == 0) ? 2'b11 : 2'b10);
            wq.push_back(e);
        end
        dc = t + lc + 1 + stall_n;
        dq.push_back(dc);
        for (int c = 1; c <= dc - t; c++) begin
            @(posedge clk);
            #1;
            start       = 1'b0;
            wr.wr_ready = !(c >= stall_idx + 1 && c <= stall_idx + stall_n);
            if (perturb && c == 2) begin
                start    = 1'b1;
                length   = 1;
                erase    = ~er;
                snake_in = ~snake_in;
            end
            if (perturb && c == dc - t) begin
                start  = 1'b1;
                length = 1;
            end
        end
        @(posedge clk);
        #1;
        start       = 1'b0;
        wr.wr_ready = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, wr.wr_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_x"}, wr.x_loc, 0);
        chk({tag, "_y"}, wr.y_loc, 0);
        chk({tag, "_data"}, wr.data_out, 0);
    endtask

    initial begin
        int    h0;
        int    t;
        wexp_t e;
        logic [4:0] xs2[4];
        logic [4:0] ys2[4];

        reset        = 1'b1;
        start        = 1'b0;
        erase        = 1'b0;
        length       = '0;
        snake_in     = '0;
        wr.wr_ready  = 1'b1;
        start2       = 1'b0;
        erase2       = 1'b0;
        length2      = '0;
        snake2       = '0;
        wr2.wr_ready = 1'b1;
        for (int i = 0; i < MS; i++) segs[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Basic draw: (y,x) = (2,5),(2,4),(2,3)
        segs[0] = 8'h25;
        segs[1] = 8'h24;
        segs[2] = 8'h23;
        do_pass(3, 1'b0, 0, 0, 1'b0);

        // Two stall cycles on segment 1
        do_pass(3, 1'b0, 1, 2, 1'b0);

        // Erase pass
        segs[0] = 8'h7A;
        segs[1] = 8'h7B;
        do_pass(2, 1'b1, 0, 0, 1'b0);

        // Empty list
        do_pass(0, 1'b0, 0, 0, 1'b0);

        // Over-long length clamps to MAX_SEG
        for (int i = 0; i < MS; i++) segs[i] = SW'(i * 7 + 3);
        h0 = hs_cnt;
        do_pass(255, 1'b0, 0, 0, 1'b0);
        chk("clamp_write_count", hs_cnt - h0, 225);

        // Mid-pass restart, input changes and start on the done cycle
        segs[0] = 8'h25;
        segs[1] = 8'h24;
        segs[2] = 8'h23;
        do_pass(3, 1'b0, 0, 0, 1'b1);

        // Reset during segment 1 aborts the pass without done
        @(posedge clk);
        #1;
        t = cyc;
        for (int i = 0; i < MS; i++) snake_in[i*SW +: SW] = segs[i];
        start  = 1'b1;
        erase  = 1'b0;
        length = 3;
        for (int i = 0; i < 2; i++) begin
            e.st  = t;
            e.cyc = t + 1 + i;
            e.x   = segs[i][3:0];
            e.y   = segs[i][7:4];
            e.d   = (i == 0) ? 2'b11 : 2'b10;
            wq.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs("abort");
        repeat (6) @(posedge clk);

        // Wider coordinates, four-segment list
        xs2 = '{5'd2, 5'd4, 5'd0, 5'd31};
        ys2 = '{5'd1, 5'd3, 5'd30, 5'd31};
        @(posedge clk);
        #1;
        for (int i = 0; i < MS2; i++) snake2[i*SW2 +: SW2] = {ys2[i], xs2[i]};
        length2 = 3'd4;
        start2  = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int i = 0; i < MS2; i++) begin
            @(negedge clk);
            chk("p2_wr_en", wr2.wr_en, 1);
            chk("p2_x_loc", wr2.x_loc, xs2[i]);
            chk("p2_y_loc", wr2.y_loc, ys2[i]);
            chk("p2_data", wr2.data_out, (i == 0) ? 3 : 2);
        end
        @(negedge clk);
        chk("p2_done", done2, 1);
        chk("p2_wr_en_end", wr2.wr_en, 0);

        repeat (3) @(posedge clk);
        mon_en = 1'b0;
        chk("writes_left", wq.size(), 0);
        chk("dones_left", dq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
